// File: rtl/mul_pkg.sv
// Purpose : shared precision encodings, latency table, controller states and result formatting.
// Latency : n/a (type and function definitions only).
// Backpress: n/a.
package mul_pkg;

    typedef enum logic [1:0] {
        PREC_8    = 2'd0,
        PREC_16   = 2'd1,
        PREC_32   = 2'd2,
        PREC_RSVD = 2'd3
    } prec_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    // Multiplier latency in cycles per precision; reserved runs at full width.
    localparam int LAT_8     = 1;
    localparam int LAT_16    = 2;
    localparam int LAT_32    = 4;
    localparam int LAT_CNT_W = 2;

    // Down-counter load value: BUSY lasts LAT cycles, counting LAT-1 .. 0.
    function automatic logic [LAT_CNT_W-1:0] cnt_load(input prec_e prec);
        case (prec)
            PREC_8:  cnt_load = LAT_CNT_W'(LAT_8 - 1);
            PREC_16: cnt_load = LAT_CNT_W'(LAT_16 - 1);
            default: cnt_load = LAT_CNT_W'(LAT_32 - 1);
        endcase
    endfunction

    // Only the low 8/16 bits of the multiplier result are meaningful at the narrow precisions.
    function automatic logic [31:0] fmt_res(input prec_e prec, input logic [31:0] res);
        case (prec)
            PREC_8:  fmt_res = {{24{res[7]}}, res[7:0]};
            PREC_16: fmt_res = {{16{res[15]}}, res[15:0]};
            default: fmt_res = res;
        endcase
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Purpose : round-robin one-hot grant over N requesters with a registered search pointer.
// Latency : grant is combinational; pointer moves on the edge where i_take is high.
// Backpress: pointer holds until the owner takes the grant.
// Ports   : i_req request vector, i_take grant consumed, o_gnt one-hot, o_gnt_id index, o_any.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [N-1:0]  i_req,
    input  logic          i_take,
    output logic [N-1:0]  o_gnt,
    output logic [IW-1:0] o_gnt_id,
    output logic          o_any
);

    localparam int            SW   = IW + 1;
    localparam logic [IW-1:0] LAST = IW'(N - 1);
    localparam logic [IW-1:0] ONE  = IW'(1);

    logic [IW-1:0] r_ptr;
    logic [IW-1:0] w_id;
    logic [SW-1:0] w_sum;
    logic          w_found;

    // Scan from r_ptr upward, wrapping at N; the first requester seen wins.
    always_comb begin
        w_found = 1'b0;
        w_id    = '0;
        w_sum   = '0;
        o_gnt   = '0;
        for (int k = 0; k < N; k++) begin
            w_sum = {1'b0, r_ptr} + SW'(k);
            if (w_sum >= SW'(N)) begin
                w_sum = w_sum - SW'(N);
            end
            if (!w_found && i_req[w_sum[IW-1:0]]) begin
                w_found = 1'b1;
                w_id    = w_sum[IW-1:0];
            end
        end
        if (w_found) begin
            o_gnt[w_id] = 1'b1;
        end
    end

    assign o_gnt_id = w_id;
    assign o_any    = w_found;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= '0;
        end else if (i_take && w_found) begin
            r_ptr <= (w_id == LAST) ? '0 : w_id + ONE;
        end
    end

endmodule

// File: rtl/mul_prec_sched.sv
// Purpose : schedules requester operations onto one shared multi-cycle multiplier by precision.
// Latency : accept in IDLE, LAT (1/2/4) BUSY cycles, then a registered response held in RESP.
// Backpress: response held until resp_ready; no requester is accepted outside IDLE.
// Ports   : req_* per-requester operands/handshake, mul_* multiplier side, resp_* result side,
//           busy (not IDLE), op_count (completed responses, wrapping).
module mul_prec_sched
    import mul_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_REQ-1:0]      req_valid,
    output logic [NUM_REQ-1:0]      req_ready,
    input  logic [NUM_REQ*16-1:0]   req_a,
    input  logic [NUM_REQ*16-1:0]   req_b,
    input  logic [NUM_REQ*2-1:0]    req_prec,
    output logic [15:0]             mul_a,
    output logic [15:0]             mul_b,
    output logic                    mul_valid,
    input  logic [31:0]             mul_res,
    output logic                    resp_valid,
    input  logic                    resp_ready,
    output logic [31:0]             resp_data,
    output logic [ID_W-1:0]         resp_id,
    output logic                    resp_err,
    output logic                    busy,
    output logic [15:0]             op_count
);

    state_e               r_state;
    state_e               w_state_nxt;
    logic [LAT_CNT_W-1:0] r_cnt;
    logic [15:0]          r_a;
    logic [15:0]          r_b;
    prec_e                r_prec;
    logic [ID_W-1:0]      r_id;
    logic                 r_mul_valid;
    logic                 r_resp_valid;
    logic [31:0]          r_resp_data;
    logic [ID_W-1:0]      r_resp_id;
    logic                 r_resp_err;
    logic [15:0]          r_op_count;

    logic [NUM_REQ-1:0]   w_gnt;
    logic [ID_W-1:0]      w_gnt_id;
    logic                 w_any;
    logic                 w_take;
    logic                 w_done;
    logic                 w_hs;
    prec_e                w_sel_prec;

    // rst_n gates the grant so no req_ready can leak while reset is held.
    assign w_take     = rst_n && (r_state == ST_IDLE) && w_any;
    assign w_done     = (r_state == ST_BUSY) && (r_cnt == '0);
    assign w_hs       = (r_state == ST_RESP) && r_resp_valid && resp_ready;
    assign w_sel_prec = prec_e'(req_prec[2*w_gnt_id +: 2]);

    rr_arbiter #(
        .N  (NUM_REQ),
        .IW (ID_W)
    ) u_arb (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_req    (req_valid),
        .i_take   (w_take),
        .o_gnt    (w_gnt),
        .o_gnt_id (w_gnt_id),
        .o_any    (w_any)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        req_ready   = '0;
        case (r_state)
            ST_IDLE: begin
                if (w_take) begin
                    w_state_nxt = ST_BUSY;
                    req_ready   = w_gnt;
                end
            end
            ST_BUSY: begin
                if (w_done) begin
                    w_state_nxt = ST_RESP;
                end
            end
            ST_RESP: begin
                if (w_hs) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt        <= '0;
            r_a          <= '0;
            r_b          <= '0;
            r_prec       <= PREC_8;
            r_id         <= '0;
            r_mul_valid  <= 1'b0;
            r_resp_valid <= 1'b0;
            r_resp_data  <= '0;
            r_resp_id    <= '0;
            r_resp_err   <= 1'b0;
            r_op_count   <= '0;
        end else begin
            // Start pulse covers exactly the first BUSY cycle.
            r_mul_valid <= w_take;
            if (w_take) begin
                r_a    <= req_a[16*w_gnt_id +: 16];
                r_b    <= req_b[16*w_gnt_id +: 16];
                r_prec <= w_sel_prec;
                r_id   <= w_gnt_id;
                r_cnt  <= cnt_load(w_sel_prec);
            end else if ((r_state == ST_BUSY) && !w_done) begin
                r_cnt <= r_cnt - LAT_CNT_W'(1);
            end
            if (w_done) begin
                r_resp_valid <= 1'b1;
                r_resp_data  <= fmt_res(r_prec, mul_res);
                r_resp_id    <= r_id;
                r_resp_err   <= (r_prec == PREC_RSVD);
            end
            if (w_hs) begin
                r_resp_valid <= 1'b0;
                r_op_count   <= r_op_count + 16'd1;
            end
        end
    end

    assign mul_a      = r_a;
    assign mul_b      = r_b;
    assign mul_valid  = r_mul_valid;
    assign resp_valid = r_resp_valid;
    assign resp_data  = r_resp_data;
    assign resp_id    = r_resp_id;
    assign resp_err   = r_resp_err;
    assign busy       = (r_state != ST_IDLE);
    assign op_count   = r_op_count;

endmodule
